// File: rtl/mont_domain_encoder_if.sv
// rtl/mont_domain_encoder_if.sv - operand/result handshake bundle for the Montgomery domain encoder
interface mont_domain_encoder_if #(
   parameter int WIDTH = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] M;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             out_err;

   // Operand source / result sink side
   modport master (
      output in_valid, X, M, out_ready,
      input  in_ready, out_valid, S, out_err
   );

   // Encoder side
   modport slave (
      input  in_valid, X, M, out_ready,
      output in_ready, out_valid, S, out_err
   );
endinterface

// File: rtl/mont_domain_encoder.sv
// rtl/mont_domain_encoder.sv - bit-serial X*2^R_BITS mod M converter into Montgomery form
module mont_domain_encoder #(
   parameter int WIDTH  = 12,
   parameter int R_BITS = WIDTH
) (
   input logic                clk,
   input logic                rst,
   mont_domain_encoder_if.slave bus
);
   localparam int CW = $clog2(R_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(R_BITS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_err;

   logic [WIDTH:0]   w_t;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_next;
   logic             w_bad;

   // One doubling step; acc < M keeps 2*acc < 2M so a single subtract suffices
   always_comb begin
      w_t    = {r_acc, 1'b0};
      w_diff = w_t - {1'b0, r_m};
      w_ge   = (w_t >= {1'b0, r_m});
      w_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
      w_bad  = ~bus.M[0] | (bus.X >= bus.M);
   end

   // Control FSM: accept in IDLE, iterate R_BITS times in CALC, hold result in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_acc <= bus.X;
                  r_m   <= bus.M;
                  r_cnt <= '0;
                  if (w_bad) begin
                     r_state <= DONE;
                     r_err   <= 1'b1;
                     r_s     <= '0;
                  end else begin
                     r_state <= CALC;
                     r_err   <= 1'b0;
                  end
               end
            end
            CALC: begin
               // The cycle after the last doubling publishes the residue
               if (r_cnt == LAST) begin
                  r_state <= DONE;
                  r_s     <= r_acc;
                  r_err   <= 1'b0;
               end else begin
                  r_acc <= w_next;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.S         = r_s;
   assign bus.out_err   = r_err;
endmodule

// File: tb/tb_mont_domain_encoder.sv
// tb/tb_mont_domain_encoder.sv - self-checking bench for mont_domain_encoder
module tb_mont_domain_encoder;
   localparam int WIDTH = 12;
   localparam int R_BITS = 12;
   localparam int LAT = R_BITS + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   mont_domain_encoder_if #(.WIDTH(WIDTH)) bus ();

   mont_domain_encoder #(.WIDTH(WIDTH), .R_BITS(R_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: X * 2^R mod M from plain integer arithmetic
   function automatic logic [WIDTH-1:0] ref_s(input int x, input int m);
      longint r;
      longint p;
      r = (longint'(1) << R_BITS) % longint'(m);
      p = (longint'(x) * r) % longint'(m);
      return WIDTH'(p);
   endfunction

   function automatic logic ref_err(input int x, input int m);
      return (m % 2 == 0) || (x >= m);
   endfunction

   // Present one operand, return edges from accept to out_valid (-1 on timeout)
   task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] m,
                        output int lat, output logic [WIDTH-1:0] s, output logic e);
      int w;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      bus.X = x;
      bus.M = m;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid || w >= 50) lat = -1;
      s = bus.S;
      e = bus.out_err;
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      n_checks++;
      if (bus.S !== '0) begin n_fail++; $display("FAIL reset_S got %0d exp 0", bus.S); end
      n_checks++;
      if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.out_err); end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] xs [4];
      int lat;
      logic [WIDTH-1:0] s;
      logic e;
      xs[0] = 12'd1234; xs[1] = 12'd0; xs[2] = 12'd1; xs[3] = 12'd4092;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_op(xs[i], 12'd4093, lat, s, e);
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL basic_lat x=%0d got %0d exp %0d", xs[i], lat, LAT); end
         n_checks++;
         if (s !== ref_s(int'(xs[i]), 4093)) begin n_fail++; $display("FAIL basic_S x=%0d got %0d exp %0d", xs[i], s, ref_s(int'(xs[i]), 4093)); end
         n_checks++;
         if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err x=%0d got %b exp 0", xs[i], e); end
      end
   endtask

   // Rejected operands go straight to DONE, visible right after the accept edge
   task automatic test_errors();
      logic [WIDTH-1:0] xs [2];
      logic [WIDTH-1:0] ms [2];
      int lat;
      logic [WIDTH-1:0] s;
      logic e;
      xs[0] = 12'd5;    ms[0] = 12'd4092;
      xs[1] = 12'd4093; ms[1] = 12'd4093;
      for (int i = 0; i < 2; i++) begin
         do_op(xs[i], ms[i], lat, s, e);
         n_checks++;
         if (lat != 0) begin n_fail++; $display("FAIL err_lat i=%0d got %0d exp 0", i, lat); end
         n_checks++;
         if (e !== 1'b1) begin n_fail++; $display("FAIL err_flag i=%0d got %b exp 1", i, e); end
         n_checks++;
         if (s !== '0) begin n_fail++; $display("FAIL err_S i=%0d got %0d exp 0", i, s); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [WIDTH-1:0] s;
      logic e;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      do_op(12'd1234, 12'd4093, lat, s, e);
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL bp_lat got %0d exp %0d", lat, LAT); end
      for (int c = 0; c < 5; c++) begin
         bus.X = 12'($urandom);
         bus.M = 12'($urandom);
         bus.in_valid = 1'b1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.S !== 12'd3702 || bus.in_ready !== 1'b0 || bus.out_err !== 1'b0)
         begin
            n_fail++;
            $display("FAIL bp_hold c=%0d got v=%b S=%0d rdy=%b err=%b exp v=1 S=3702 rdy=0 err=0",
                     c, bus.out_valid, bus.S, bus.in_ready, bus.out_err);
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      int seen;
      logic [WIDTH-1:0] s;
      logic e;
      bus.X = 12'd1234;
      bus.M = 12'd4093;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== '0 || bus.out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid got rdy=%b v=%b S=%0d err=%b exp rdy=1 v=0 S=0 err=0",
                  bus.in_ready, bus.out_valid, bus.S, bus.out_err);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.out_valid) seen++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL rst_no_valid got %0d pulses exp 0", seen); end
      do_op(12'd1, 12'd4093, lat, s, e);
      n_checks++;
      if (lat != LAT || s !== 12'd3 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_recover got lat=%0d S=%0d err=%b exp lat=%0d S=3 err=0", lat, s, e, LAT);
      end
   endtask

   // in_valid held high across two operands; second accept only once IDLE again
   task automatic test_back_to_back();
      int nres;
      int t_res [2];
      logic [WIDTH-1:0] s_res [2];
      logic seen_idle;
      int w;
      nres = 0;
      seen_idle = 1'b0;
      w = 0;
      while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      bus.out_ready = 1'b1;
      bus.X = 12'd7;
      bus.M = 12'd4093;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.X = 12'd100;
      for (int c = 1; c <= 60 && nres < 2; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            t_res[nres] = c;
            s_res[nres] = bus.S;
            nres++;
         end
         if (nres >= 1 && bus.in_ready) seen_idle = 1'b1;
         if (seen_idle && !bus.in_ready) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (nres != 2) begin
         n_fail++;
         $display("FAIL b2b_count got %0d results exp 2", nres);
      end else begin
         n_checks++;
         if (s_res[0] !== 12'd21 || s_res[1] !== 12'd300) begin
            n_fail++;
            $display("FAIL b2b_S got %0d,%0d exp 21,300", s_res[0], s_res[1]);
         end
         n_checks++;
         if (t_res[0] != LAT || t_res[1] != 2 * LAT + 2) begin
            n_fail++;
            $display("FAIL b2b_timing got %0d,%0d exp %0d,%0d", t_res[0], t_res[1], LAT, 2 * LAT + 2);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [WIDTH-1:0] s;
      logic e;
      int x, m, elat;
      logic eerr;
      logic [WIDTH-1:0] es;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         m = int'($urandom_range(1, 4095));
         if ($urandom_range(0, 7) != 0) m = m | 1;
         if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 4095));
         else x = int'($urandom_range(0, m - 1));
         eerr = ref_err(x, m);
         es = eerr ? '0 : ref_s(x, m);
         elat = eerr ? 0 : LAT;
         do_op(WIDTH'(x), WIDTH'(m), lat, s, e);
         n_checks++;
         if (lat != elat || s !== es || e !== eerr) begin
            n_fail++;
            $display("FAIL rand x=%0d m=%0d got lat=%0d S=%0d err=%b exp lat=%0d S=%0d err=%b",
                     x, m, lat, s, e, elat, es, eerr);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.X = '0;
      bus.M = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_errors();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      test_random();
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
